// File: rtl/hash_job_sequencer.sv
// Runs a table of hash-core jobs back to back, times each one and returns one result record per job.
// Optional statistics outputs are enabled by defining HASH_JOB_SEQ_STATS_EN.
module hash_job_sequencer #(
    parameter int NUM_JOBS   = 4,
    parameter int JOB_AW     = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1,
    parameter int TARGET_W   = 8,
    parameter int ENTR_W     = 2,
    parameter int NONCE_W    = 32,
    parameter int BOUNTY_W   = 24,
    parameter int CYC_W      = 24,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                job_wr_en,
    input  logic [JOB_AW-1:0]   job_wr_addr,
    input  logic [TARGET_W-1:0] job_wr_target,
    input  logic [ENTR_W-1:0]   job_wr_entradas,
    output logic                core_reset_L,
    output logic [TARGET_W-1:0] target,
    output logic [ENTR_W-1:0]   num_entradas,
    input  logic                fin,
    input  logic [NONCE_W-1:0]  nonce_valido_out,
    input  logic [BOUNTY_W-1:0] bounty_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [JOB_AW-1:0]   res_job,
    output logic [NONCE_W-1:0]  res_nonce,
    output logic [BOUNTY_W-1:0] res_bounty,
    output logic [CYC_W-1:0]    res_cycles,
    output logic                res_timeout,
`ifdef HASH_JOB_SEQ_STATS_EN
    output logic [CYC_W+JOB_AW-1:0] stat_total_cycles,
    output logic [JOB_AW:0]         stat_timeouts,
    output logic [CYC_W-1:0]        stat_min_cycles,
    output logic [CYC_W-1:0]        stat_max_cycles,
`endif
    output logic                busy,
    output logic                done
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_r, state_nx;
    logic [JOB_AW-1:0]   job_r, job_nx;
    logic [RC_W-1:0]     rst_cnt_r, rst_cnt_nx;
    logic [CYC_W-1:0]    cyc_r, cyc_nx;
    logic                core_reset_l_r, core_reset_l_nx;
    logic [TARGET_W-1:0] target_r, target_nx;
    logic [ENTR_W-1:0]   entr_r, entr_nx;
    logic                res_valid_r, res_valid_nx;
    logic [NONCE_W-1:0]  res_nonce_r, res_nonce_nx;
    logic [BOUNTY_W-1:0] res_bounty_r, res_bounty_nx;
    logic [CYC_W-1:0]    res_cycles_r, res_cycles_nx;
    logic                res_timeout_r, res_timeout_nx;
    logic                busy_r, busy_nx;
    logic                done_r, done_nx;
    logic                idle_s;
    logic                accept_s;

    logic [TARGET_W-1:0] tab_target_r [NUM_JOBS];
    logic [ENTR_W-1:0]   tab_entr_r   [NUM_JOBS];

    assign idle_s   = (state_r == IDLE) || (state_r == DONE);
    assign accept_s = (state_r == HOLD) && res_ready;

    // Job table: written only while idle, deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (idle_s && job_wr_en && (32'(job_wr_addr) < NUM_JOBS)) begin
            tab_target_r[job_wr_addr] <= job_wr_target;
            tab_entr_r[job_wr_addr]   <= job_wr_entradas;
        end
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_nx        = state_r;
        job_nx          = job_r;
        rst_cnt_nx      = rst_cnt_r;
        cyc_nx          = cyc_r;
        core_reset_l_nx = core_reset_l_r;
        target_nx       = target_r;
        entr_nx         = entr_r;
        res_valid_nx    = res_valid_r;
        res_nonce_nx    = res_nonce_r;
        res_bounty_nx   = res_bounty_r;
        res_cycles_nx   = res_cycles_r;
        res_timeout_nx  = res_timeout_r;
        busy_nx         = busy_r;
        done_nx         = done_r;
        case (state_r)
            IDLE, DONE: begin
                core_reset_l_nx = 1'b0;
                if (start) begin
                    state_nx   = ARM;
                    job_nx     = '0;
                    rst_cnt_nx = '0;
                    busy_nx    = 1'b1;
                    done_nx    = 1'b0;
                end else begin
                    state_nx = state_r;
                end
            end
            ARM: begin
                target_nx       = tab_target_r[job_r];
                entr_nx         = tab_entr_r[job_r];
                core_reset_l_nx = 1'b0;
                if (rst_cnt_r == RC_W'(RST_CYCLES - 1)) begin
                    state_nx        = RUN;
                    core_reset_l_nx = 1'b1;
                    cyc_nx          = '0;
                end else begin
                    rst_cnt_nx = rst_cnt_r + 1'b1;
                end
            end
            RUN: begin
                cyc_nx = (&cyc_r) ? cyc_r : cyc_r + 1'b1;
                // A fin arriving in the timeout cycle still counts as a success
                if (fin) begin
                    res_nonce_nx    = nonce_valido_out;
                    res_bounty_nx   = bounty_out;
                    res_cycles_nx   = cyc_r;
                    res_timeout_nx  = 1'b0;
                    res_valid_nx    = 1'b1;
                    core_reset_l_nx = 1'b0;
                    state_nx        = HOLD;
                end else if (cyc_r == CYC_W'(TIMEOUT - 1)) begin
                    res_nonce_nx    = '0;
                    res_bounty_nx   = '0;
                    res_cycles_nx   = CYC_W'(TIMEOUT);
                    res_timeout_nx  = 1'b1;
                    res_valid_nx    = 1'b1;
                    core_reset_l_nx = 1'b0;
                    state_nx        = HOLD;
                end else begin
                    state_nx = RUN;
                end
            end
            HOLD: begin
                core_reset_l_nx = 1'b0;
                if (res_ready) begin
                    res_valid_nx = 1'b0;
                    if (job_r == JOB_AW'(NUM_JOBS - 1)) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx   = ARM;
                        job_nx     = job_r + 1'b1;
                        rst_cnt_nx = '0;
                    end
                end else begin
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx        = IDLE;
                core_reset_l_nx = 1'b0;
                res_valid_nx    = 1'b0;
                busy_nx         = 1'b0;
                done_nx         = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            job_r          <= '0;
            rst_cnt_r      <= '0;
            cyc_r          <= '0;
            core_reset_l_r <= 1'b0;
            target_r       <= '0;
            entr_r         <= '0;
            res_valid_r    <= 1'b0;
            res_nonce_r    <= '0;
            res_bounty_r   <= '0;
            res_cycles_r   <= '0;
            res_timeout_r  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nx;
            job_r          <= job_nx;
            rst_cnt_r      <= rst_cnt_nx;
            cyc_r          <= cyc_nx;
            core_reset_l_r <= core_reset_l_nx;
            target_r       <= target_nx;
            entr_r         <= entr_nx;
            res_valid_r    <= res_valid_nx;
            res_nonce_r    <= res_nonce_nx;
            res_bounty_r   <= res_bounty_nx;
            res_cycles_r   <= res_cycles_nx;
            res_timeout_r  <= res_timeout_nx;
            busy_r         <= busy_nx;
            done_r         <= done_nx;
        end
    end

    assign core_reset_L = core_reset_l_r;
    assign target       = target_r;
    assign num_entradas = entr_r;
    assign res_valid    = res_valid_r;
    assign res_job      = job_r;
    assign res_nonce    = res_nonce_r;
    assign res_bounty   = res_bounty_r;
    assign res_cycles   = res_cycles_r;
    assign res_timeout  = res_timeout_r;
    assign busy         = busy_r;
    assign done         = done_r;

`ifdef HASH_JOB_SEQ_STATS_EN
    logic [CYC_W+JOB_AW-1:0] stat_total_r;
    logic [JOB_AW:0]         stat_to_r;
    logic [CYC_W-1:0]        stat_min_r;
    logic [CYC_W-1:0]        stat_max_r;
    logic [CYC_W+JOB_AW:0]   total_sum_s;

    // Saturating running total of accepted cycle counts
    always_comb begin
        total_sum_s = {1'b0, stat_total_r} + (CYC_W + JOB_AW + 1)'(res_cycles_r);
    end

    // Statistics accumulate on each accepted record, cleared when a sequence starts
    always_ff @(posedge clk) begin
        if (reset || (idle_s && start)) begin
            stat_total_r <= '0;
            stat_to_r    <= '0;
            stat_min_r   <= '1;
            stat_max_r   <= '0;
        end else if (accept_s) begin
            stat_total_r <= total_sum_s[CYC_W+JOB_AW] ? '1 : total_sum_s[CYC_W+JOB_AW-1:0];
            if (res_timeout_r) begin
                stat_to_r <= stat_to_r + 1'b1;
            end else begin
                if (res_cycles_r < stat_min_r) stat_min_r <= res_cycles_r;
                if (res_cycles_r > stat_max_r) stat_max_r <= res_cycles_r;
            end
        end
    end

    assign stat_total_cycles = stat_total_r;
    assign stat_timeouts     = stat_to_r;
    assign stat_min_cycles   = stat_min_r;
    assign stat_max_cycles   = stat_max_r;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_hash_job_sequencer.sv
// Directed bench for hash_job_sequencer with a behavioural hash-core model.
module tb_hash_job_sequencer;
    localparam int NJ = 4, AW = 2, TW = 8, EW = 2, NW = 32, BW = 24, CW = 24;

    logic          clk, reset, start, job_wr_en;
    logic [AW-1:0] job_wr_addr;
    logic [TW-1:0] job_wr_target, target;
    logic [EW-1:0] job_wr_entradas, num_entradas;
    logic          core_reset_L, fin, res_valid, res_ready, res_timeout, busy, done;
    logic [NW-1:0] nonce_valido_out, res_nonce;
    logic [BW-1:0] bounty_out, res_bounty;
    logic [AW-1:0] res_job;
    logic [CW-1:0] res_cycles;
`ifdef HASH_JOB_SEQ_STATS_EN
    logic [CW+AW-1:0] stat_total_cycles;
    logic [AW:0]      stat_timeouts;
    logic [CW-1:0]    stat_min_cycles, stat_max_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tb_tgt   [NJ] = '{8'h0F, 8'h10, 8'h20, 8'h05};
    logic [1:0] tb_ent   [NJ] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] tb_nonce [NJ] = '{32'hA000_000F, 32'hA000_0010, 32'hA000_0020, 32'hA000_0005};
    logic [23:0] tb_bnty  [NJ] = '{24'hB0_000F, 24'hB0_0010, 24'hB0_0020, 24'hB0_0005};
    int          tb_delay [NJ];

    hash_job_sequencer #(.NUM_JOBS(NJ), .TARGET_W(TW), .ENTR_W(EW), .NONCE_W(NW),
                         .BOUNTY_W(BW), .CYC_W(CW), .RST_CYCLES(2), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .start(start), .job_wr_en(job_wr_en),
        .job_wr_addr(job_wr_addr), .job_wr_target(job_wr_target),
        .job_wr_entradas(job_wr_entradas), .core_reset_L(core_reset_L),
        .target(target), .num_entradas(num_entradas), .fin(fin),
        .nonce_valido_out(nonce_valido_out), .bounty_out(bounty_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_job(res_job),
        .res_nonce(res_nonce), .res_bounty(res_bounty), .res_cycles(res_cycles),
        .res_timeout(res_timeout),
`ifdef HASH_JOB_SEQ_STATS_EN
        .stat_total_cycles(stat_total_cycles), .stat_timeouts(stat_timeouts),
        .stat_min_cycles(stat_min_cycles), .stat_max_cycles(stat_max_cycles),
`endif
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: fin pulses tb_delay cycles after core_reset_L rises (-1 = never)
    initial begin
        int run_cnt;
        int dly;
        run_cnt = 0;
        fin = 1'b0;
        nonce_valido_out = 32'h0;
        bounty_out = 24'h0;
        forever begin
            @(posedge clk);
            #1;
            dly = -1;
            for (int i = 0; i < NJ; i++) if (target == tb_tgt[i]) dly = tb_delay[i];
            nonce_valido_out = 32'hA000_0000 | {24'h0, target};
            bounty_out       = 24'hB0_0000 | {16'h0, target};
            if (core_reset_L) begin
                fin = (run_cnt == dly);
                run_cnt++;
            end else begin
                fin = 1'b0;
                run_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_job(input int a, input logic [7:0] t, input logic [1:0] e);
        job_wr_en = 1'b1;
        job_wr_addr = 2'(a);
        job_wr_target = t;
        job_wr_entradas = e;
        tick();
        job_wr_en = 1'b0;
    endtask

    task automatic start_seq();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("done_cleared", done, 1'b0);
        n = 1;
        while (!core_reset_L && n < 10) begin
            tick();
            n++;
        end
        check("start_latency", 64'(n), 64'd3);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!res_valid && n < 400) begin
            tick();
            n++;
        end
        check("wait_valid", res_valid, 1'b1);
    endtask

    task automatic chk_record(input int j, input logic [23:0] cyc, input logic to,
                              input logic [31:0] ne, input logic [23:0] be);
        wait_valid();
        check($sformatf("job%0d_idx", j), res_job, 64'(j));
        check($sformatf("job%0d_cycles", j), res_cycles, cyc);
        check($sformatf("job%0d_timeout", j), res_timeout, to);
        check($sformatf("job%0d_nonce", j), res_nonce, ne);
        check($sformatf("job%0d_bounty", j), res_bounty, be);
        check($sformatf("job%0d_target", j), target, tb_tgt[j]);
        check($sformatf("job%0d_entradas", j), num_entradas, tb_ent[j]);
        check($sformatf("job%0d_core_held", j), core_reset_L, 1'b0);
    endtask

    task automatic accept_and_check();
        tick();
        check("valid_drop", res_valid, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; job_wr_en = 1'b0; job_wr_addr = '0;
        job_wr_target = '0; job_wr_entradas = '0; res_ready = 1'b1;
        for (int i = 0; i < NJ; i++) tb_delay[i] = 50;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_outputs", {core_reset_L, res_valid, busy, done, res_timeout}, 5'b0);
        check("rst_target", {target, num_entradas}, 10'h0);
        check("rst_record", {res_job, res_cycles, res_nonce, res_bounty}, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {core_reset_L, res_valid, busy}, 3'b0);
        end
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        check("start_in_reset", {busy, core_reset_L}, 2'b0);

        for (int i = 0; i < NJ; i++) write_job(i, tb_tgt[i], tb_ent[i]);

        // All jobs finish 50 cycles after release
        start_seq();
        for (int j = 0; j < NJ; j++) begin
            chk_record(j, 24'd50, 1'b0, tb_nonce[j], tb_bnty[j]);
            accept_and_check();
        end
        check("seq1_done", {done, busy}, 2'b10);

        // 30, 70, timeout, 50 with back-pressure on job 1
        tb_delay[0] = 30; tb_delay[1] = 70; tb_delay[2] = -1; tb_delay[3] = 50;
        start_seq();
        chk_record(0, 24'd30, 1'b0, tb_nonce[0], tb_bnty[0]);
        accept_and_check();
        res_ready = 1'b0;
        chk_record(1, 24'd70, 1'b0, tb_nonce[1], tb_bnty[1]);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_stable", {res_valid, res_job, res_cycles, core_reset_L},
                  {1'b1, 2'd1, 24'd70, 1'b0});
        end
        res_ready = 1'b1;
        accept_and_check();
        chk_record(2, 24'd100, 1'b1, 32'h0, 24'h0);
        accept_and_check();
        chk_record(3, 24'd50, 1'b0, tb_nonce[3], tb_bnty[3]);
        accept_and_check();
        check("seq2_done", {done, busy}, 2'b10);
`ifdef HASH_JOB_SEQ_STATS_EN
        check("stat_total", stat_total_cycles, 26'd250);
        check("stat_timeouts", stat_timeouts, 3'd1);
        check("stat_min", stat_min_cycles, 24'd30);
        check("stat_max", stat_max_cycles, 24'd70);
`endif

        // Writes and start while busy are ignored; reset in RUN aborts
        start_seq();
        job_wr_en = 1'b1; job_wr_addr = 2'd0; job_wr_target = 8'hEE; job_wr_entradas = 2'd3;
        start = 1'b1;
        tick();
        job_wr_en = 1'b0; start = 1'b0;
        check("busy_write_target", target, 8'h0F);
        chk_record(0, 24'd30, 1'b0, tb_nonce[0], tb_bnty[0]);
        accept_and_check();
        n = 0;
        while (!core_reset_L && n < 20) begin
            tick();
            n++;
        end
        check("job1_running", core_reset_L, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", {busy, res_valid, core_reset_L, done}, 4'b0);
        check("abort_target", target, 8'h00);
        start_seq();
        chk_record(0, 24'd30, 1'b0, tb_nonce[0], tb_bnty[0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_idle", {busy, res_valid}, 2'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hash_job_sequencer.md
Name: hash_job_sequencer

Overview:
Synthesizable, parametrised successor to the fixed-stimulus hash-core driver. Holds a table of NUM_JOBS mining jobs (target, num_entradas), runs them back-to-back on one hash core, and times each job in clock cycles. Returns one result record per job (nonce, bounty, cycle count, timeout flag) over a valid/ready handshake. Sits between the host/test harness and the hash core in the throughput-measurement (velocidad) setup.

Parameters:
NUM_JOBS, 4, job table depth (1..16); JOB_AW = clog2 of NUM_JOBS, minimum 1
TARGET_W, 8, target width
ENTR_W, 2, num_entradas width
NONCE_W, 32, nonce width
BOUNTY_W, 24, bounty width
CYC_W, 24, cycle counter width
RST_CYCLES, 2, cycles core_reset_L is held low before each job (>=1)
TIMEOUT, 1000000, cycles in RUN before the job is abandoned (< 2^CYC_W)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse; begins the sequence when IDLE/DONE
job_wr_en  in  1  write job table entry (ignored unless IDLE/DONE)
job_wr_addr  in  JOB_AW  entry index
job_wr_target  in  TARGET_W  target for entry
job_wr_entradas  in  ENTR_W  num_entradas for entry
core_reset_L  out  1  active-low reset to hash core
target  out  TARGET_W  to core
num_entradas  out  ENTR_W  to core
fin  in  1  core done
nonce_valido_out  in  NONCE_W  core nonce
bounty_out  in  BOUNTY_W  core bounty
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts record
res_job  out  JOB_AW  job index of record
res_nonce  out  NONCE_W
res_bounty  out  BOUNTY_W
res_cycles  out  CYC_W  cycles from core_reset_L rise to fin (or TIMEOUT)
res_timeout  out  1  job abandoned
busy  out  1  high outside IDLE/DONE
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; core_reset_L=0, target=0, num_entradas=0, res_valid=0, all res_* =0, busy=0, done=0, job index=0, counters=0. Job table is NOT cleared by reset (contents preserved).
- States: IDLE, ARM, RUN, HOLD, DONE.
- IDLE/DONE: core_reset_L=0. start=1 -> ARM with job=0, rst_cnt=0; done clears next cycle. job_wr_en writes table (write wins; start in same cycle uses new entry 0 contents only from next cycle, ARM reads table in ARM).
- ARM: target/num_entradas driven from table[job] (registered, stable until next ARM). core_reset_L=0 for RST_CYCLES cycles, then -> RUN, core_reset_L=1, cyc=0.
- RUN: cyc increments each cycle, saturating at 2^CYC_W-1. fin=1 -> capture nonce/bounty, res_cycles=cyc, res_timeout=0, -> HOLD. cyc==TIMEOUT-1 without fin -> res_nonce=0, res_bounty=0, res_cycles=TIMEOUT, res_timeout=1, -> HOLD. fin in the timeout cycle counts as success.
- HOLD: res_valid=1, core_reset_L=0 (core frozen); record stable until res_valid&res_ready. On handshake: if job==NUM_JOBS-1 -> DONE, else job+1 -> ARM. res_valid drops the cycle after handshake unless a new record is ready (min 1 RST_CYCLES gap guarantees drop).
- res_ready ignored when res_valid=0. fin ignored outside RUN.
- job_wr_en while busy: ignored, table unchanged. start while busy: ignored.
- reset mid-sequence: returns to IDLE next edge, pending record dropped, core_reset_L=0.
- Latency: start -> core_reset_L high = 1 + RST_CYCLES cycles; fin -> res_valid = 1 cycle.

Optional Feature:
HASH_JOB_SEQ_STATS_EN: adds outputs stat_total_cycles (CYC_W+JOB_AW bits, sum of res_cycles of all accepted records, saturating), stat_timeouts (JOB_AW+1 bits), stat_min_cycles and stat_max_cycles (CYC_W, over non-timeout jobs; min resets to all-ones, max to 0). Cleared by reset and by an accepted start; updated on each res handshake. Without macro: ports and logic absent, behaviour otherwise identical.

Test Plan:
- Reset then idle: core_reset_L=0, res_valid=0, busy=0 for 10 cycles; start with reset=1 -> no action.
- NUM_JOBS=4, table {(8'h0F,1),(8'h10,2),(8'h20,3),(8'h05,0)}, model fin 50 cycles after core_reset_L rise, res_ready=1 -> 4 records, res_job 0..3, res_cycles=50, targets presented in order, done=1.
- TIMEOUT=100, core never asserts fin -> res_timeout=1, res_cycles=100, nonce=0, next job starts ARM after handshake.
- res_ready low 20 cycles on job 1 -> record held stable, core_reset_L=0, job 2 not started until handshake.
- job_wr_en and start during RUN -> table and sequence unaffected; reset asserted in RUN -> IDLE next cycle, res_valid=0.
- With HASH_JOB_SEQ_STATS_EN, jobs finishing at 30,70 plus one timeout (100) -> total=200, timeouts=1, min=30, max=70.
